// File: rtl/serial_frame_rx_if.sv
// rtl/serial_frame_rx_if.sv - serial line input and received-byte bus of serial_frame_rx
interface serial_frame_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  transmit_data;
    logic                  received_n;
    logic [DATA_WIDTH-1:0] received_data;
    logic                  frame_err;
    logic                  parity_err;
    logic                  busy;

    modport master (
        input  transmit_data,
        output received_n,
        output received_data,
        output frame_err,
        output parity_err,
        output busy
    );

    modport slave (
        output transmit_data,
        input  received_n,
        input  received_data,
        input  frame_err,
        input  parity_err,
        input  busy
    );
endinterface

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - oversampled serial frame receiver; SERIAL_FRAME_RX_PARITY_EN adds even parity
module serial_frame_rx #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    serial_frame_rx_if.master bus
);
    // ADDR_WIDTH only exists so every block in the device shares one parameter set.
    localparam int BAUD_W = $clog2(CLKS_PER_BIT) + 0 * ADDR_WIDTH;
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
    localparam logic [BAUD_W-1:0] HALF_M1  = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_M1  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SERIAL_FRAME_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t                state;
    logic [BAUD_W-1:0]     baud_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_n_q;
    logic                  frame_err_q;
    logic                  busy_q;
    logic                  line;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic                  parity_err_q;
    logic                  parity_bad;
`endif

    assign line = bus.transmit_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            rx_data_q   <= '0;
            rx_n_q      <= 1'b1;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            parity_err_q <= 1'b0;
            parity_bad   <= 1'b0;
`endif
        end else begin
            rx_n_q      <= 1'b1;
            frame_err_q <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!line) begin
                        state    <= START;
                        baud_cnt <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_M1) begin
                        baud_cnt <= '0;
                        if (!line) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == FULL_M1) begin
                        baud_cnt  <= '0;
                        shift_reg <= DATA_WIDTH'({line, shift_reg} >> 1);
                        if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef SERIAL_FRAME_RX_PARITY_EN
                PARITY: begin
                    if (baud_cnt == FULL_M1) begin
                        baud_cnt   <= '0;
                        parity_bad <= line ^ (^shift_reg);
                        state      <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_cnt == FULL_M1) begin
                        baud_cnt <= '0;
                        if (line) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                            if (parity_bad) begin
                                parity_err_q <= 1'b1;
                            end else begin
                                rx_data_q <= shift_reg;
                                rx_n_q    <= 1'b0;
                            end
`else
                            rx_data_q <= shift_reg;
                            rx_n_q    <= 1'b0;
`endif
                        end else begin
                            frame_err_q <= 1'b1;
                            state       <= BREAK;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                // A line held low after a framing error must not look like a new start bit.
                BREAK: begin
                    if (line) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.received_n    = rx_n_q;
    assign bus.received_data = rx_data_q;
    assign bus.frame_err     = frame_err_q;
    assign bus.busy          = busy_q;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    assign bus.parity_err    = parity_err_q;
`else
    assign bus.parity_err    = 1'b0;
`endif
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - directed self-checking bench for serial_frame_rx
module tb_serial_frame_rx;
    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    localparam int LAT       = 42;
    localparam int FRAME_CYC = 44;
`else
    localparam int LAT       = 38;
    localparam int FRAME_CYC = 40;
`endif

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    int   overlap;

    int          strobe_cyc[$];
    logic [7:0]  strobe_data[$];
    int          ferr_cyc[$];
    int          perr_cyc[$];

`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic par_flip;
`endif

    serial_frame_rx_if #(.DATA_WIDTH(DW)) bus ();

    serial_frame_rx #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (4),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial overlap = 0;
    always @(negedge clk) begin
        if (bus.received_n === 1'b0) begin
            strobe_cyc.push_back(cyc);
            strobe_data.push_back(bus.received_data);
        end
        if (bus.frame_err === 1'b1) ferr_cyc.push_back(cyc);
        if (bus.parity_err === 1'b1) perr_cyc.push_back(cyc);
        if ((32'(bus.received_n === 1'b0) + 32'(bus.frame_err === 1'b1) + 32'(bus.parity_err === 1'b1)) > 1)
            overlap++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int q_int(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic logic [7:0] q_byte(input logic [7:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 8'hxx;
    endfunction

    task automatic clear_logs();
        strobe_cyc.delete();
        strobe_data.delete();
        ferr_cyc.delete();
        perr_cyc.delete();
    endtask

    // Called on a negedge; returns on the negedge that ends the bit.
    task automatic drive_bit(input logic b);
        bus.transmit_data = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, output int t0);
        t0 = cyc + 1;
        drive_bit(1'b0);
        for (int k = 0; k < DW; k++) drive_bit(d[k]);
`ifdef SERIAL_FRAME_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
        drive_bit(stop_b);
    endtask

    initial begin
        int t0;
        int t1;
        int busy_lo;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.transmit_data = 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
        par_flip = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_received_n", 32'(bus.received_n), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_data", 32'(bus.received_data), 32'h00);
        rst = 1'b0;

        repeat (100) @(negedge clk);
        check("idle_received_n", 32'(bus.received_n), 32'd1);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_data", 32'(bus.received_data), 32'h00);
        check("idle_flags", 32'({bus.frame_err, bus.parity_err}), 32'd0);
        check("idle_strobes", 32'(strobe_cyc.size()), 32'd0);

        clear_logs();
        send_frame(8'hA5, 1'b1, t0);
        check("a5_strobe_count", 32'(strobe_cyc.size()), 32'd1);
        check("a5_strobe_cycle", 32'(q_int(strobe_cyc, 0)), 32'(t0 + LAT));
        check("a5_strobe_data", 32'(q_byte(strobe_data, 0)), 32'hA5);
        check("a5_held_data", 32'(bus.received_data), 32'hA5);
        check("a5_frame_err", 32'(ferr_cyc.size()), 32'd0);

        clear_logs();
        send_frame(8'h3C, 1'b1, t0);
        send_frame(8'hC3, 1'b1, t1);
        check("b2b_start_gap", 32'(t1 - t0), 32'(FRAME_CYC));
        check("b2b_strobe_count", 32'(strobe_cyc.size()), 32'd2);
        check("b2b_first_cycle", 32'(q_int(strobe_cyc, 0)), 32'(t0 + LAT));
        check("b2b_spacing", 32'(q_int(strobe_cyc, 1) - q_int(strobe_cyc, 0)), 32'(FRAME_CYC));
        check("b2b_first_data", 32'(q_byte(strobe_data, 0)), 32'h3C);
        check("b2b_second_data", 32'(q_byte(strobe_data, 1)), 32'hC3);

        clear_logs();
        bus.transmit_data = 1'b0;
        @(negedge clk);
        bus.transmit_data = 1'b1;
        @(negedge clk);
        check("glitch_busy_start", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("glitch_busy_reject", 32'(bus.busy), 32'd0);
        repeat (20) @(negedge clk);
        check("glitch_no_strobe", 32'(strobe_cyc.size()), 32'd0);
        check("glitch_no_flags", 32'(ferr_cyc.size() + perr_cyc.size()), 32'd0);

        clear_logs();
        send_frame(8'h5A, 1'b0, t0);
        check("ferr_count", 32'(ferr_cyc.size()), 32'd1);
        check("ferr_cycle", 32'(q_int(ferr_cyc, 0)), 32'(t0 + LAT));
        check("ferr_no_strobe", 32'(strobe_cyc.size()), 32'd0);
        check("ferr_data_kept", 32'(bus.received_data), 32'hC3);
        busy_lo = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) busy_lo++;
        end
        check("break_busy_held", 32'(busy_lo), 32'd0);
        check("break_no_restart", 32'(strobe_cyc.size() + ferr_cyc.size()), 32'd1);
        bus.transmit_data = 1'b1;
        @(negedge clk);
        check("break_release", 32'(bus.busy), 32'd0);
        clear_logs();
        send_frame(8'h01, 1'b1, t0);
        check("after_break_cycle", 32'(q_int(strobe_cyc, 0)), 32'(t0 + LAT));
        check("after_break_data", 32'(bus.received_data), 32'h01);

        clear_logs();
        t0 = cyc + 1;
        drive_bit(1'b0);
        for (int k = 0; k < 4; k++) drive_bit(1'b1);
        check("midrst_busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_data", 32'(bus.received_data), 32'h00);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_no_strobe", 32'(strobe_cyc.size()), 32'd0);
        check("midrst_idle", 32'(bus.busy), 32'd0);

`ifdef SERIAL_FRAME_RX_PARITY_EN
        clear_logs();
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1, t0);
        check("perr_count", 32'(perr_cyc.size()), 32'd1);
        check("perr_cycle", 32'(q_int(perr_cyc, 0)), 32'(t0 + LAT));
        check("perr_no_strobe", 32'(strobe_cyc.size()), 32'd0);
        check("perr_data_kept", 32'(bus.received_data), 32'h00);
        clear_logs();
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1, t0);
        check("par_ok_data", 32'(q_byte(strobe_data, 0)), 32'h07);
        check("par_ok_no_perr", 32'(perr_cyc.size()), 32'd0);
`else
        check("no_parity_err_ever", 32'(perr_cyc.size()), 32'd0);
`endif
        check("flags_exclusive", 32'(overlap), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
